// File: rtl/dual_counter_pkg.sv
// Shared types and constants for the unwinding dual counter.
// Holds the phase enum, default sizing and the expected-y helper.
package dual_counter_pkg;

    typedef enum logic [1:0] {
        RUN_HI = 2'd0,
        RUN_LO = 2'd1,
        DONE   = 2'd2
    } phase_e;

    localparam int W_DEF      = 11;
    localparam int X_MAX_DEF  = 200;
    localparam int X_KNEE_DEF = 100;
    localparam int Y_INIT_DEF = 100;

    // y tracks x one-for-one above the knee and sits on its floor below it.
    function automatic int unsigned knee_offset(
        input int unsigned x,
        input int unsigned knee,
        input int unsigned yinit
    );
        return yinit + ((x > knee) ? (x - knee) : 32'd0);
    endfunction

endpackage

// File: rtl/dual_counter_unwind_chk.sv
// Invariant checker for dual_counter_unwind; observes outputs only.
// Ports: clk, rst, x, y, steps, phase, done (all inputs).
module dual_counter_unwind_chk
    import dual_counter_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int X_MAX  = X_MAX_DEF,
    parameter int X_KNEE = X_KNEE_DEF,
    parameter int Y_INIT = Y_INIT_DEF
) (
    input logic         clk,
    input logic         rst,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [W-1:0] steps,
    input logic [1:0]   phase,
    input logic         done
);

    localparam logic [W-1:0] XM = W'(X_MAX);
    localparam logic [W-1:0] KN = W'(X_KNEE);
    localparam logic [W-1:0] YI = W'(Y_INIT);

    // Outputs are meaningless until the first reset has been applied.
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) armed <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (armed === 1'b1) begin
            a_y : assert (32'(y) == knee_offset(32'(x), X_KNEE, Y_INIT))
                else $error("y invariant broken");
            a_steps : assert (steps == XM - x)
                else $error("steps invariant broken");
            a_floor : assert ((x != '0) || (y == YI))
                else $error("y floor invariant broken");
            a_done : assert (done == (x == '0))
                else $error("done invariant broken");
            a_phase : assert ((phase == RUN_HI) == (x > KN))
                else $error("phase invariant broken");
            a_enc : assert (phase != 2'd3)
                else $error("illegal phase encoding");
        end
    end

endmodule

// File: rtl/dual_counter_unwind.sv
// Dual down-counter: x and y unwind together to the knee, then x alone.
// Ports: clk, rst, selector, restart in; x, y, steps, phase, done out.
module dual_counter_unwind
    import dual_counter_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int X_MAX  = X_MAX_DEF,
    parameter int X_KNEE = X_KNEE_DEF,
    parameter int Y_INIT = Y_INIT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         selector,
    input  logic         restart,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic [W-1:0] steps,
    output logic [1:0]   phase,
    output logic         done
);

    generate
        if ((X_KNEE >= X_MAX) || (X_KNEE < 0) ||
            ((longint'(Y_INIT) + X_MAX - X_KNEE) >= (longint'(1) << W)))
        begin : g_bad_params
            $error("dual_counter_unwind: illegal parameters");
        end
    endgenerate

    localparam logic [W-1:0] X0 = W'(X_MAX);
    localparam logic [W-1:0] Y0 = W'(Y_INIT + X_MAX - X_KNEE);
    localparam logic [W-1:0] KN = W'(X_KNEE);

    phase_e       st_q, st_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] s_q, s_d;
    logic         dn_q, dn_d;

    always_comb begin
        st_d = st_q;
        x_d  = x_q;
        y_d  = y_q;
        s_d  = s_q;
        if (restart) begin
            st_d = RUN_HI;
            x_d  = X0;
            y_d  = Y0;
            s_d  = '0;
        end else if (selector) begin
            unique case (st_q)
                RUN_HI: begin
                    x_d = x_q - 1'b1;
                    y_d = y_q - 1'b1;
                    s_d = s_q + 1'b1;
                    // A zero knee means the lock-step run ends the count.
                    if (x_d == '0)      st_d = DONE;
                    else if (x_d == KN) st_d = RUN_LO;
                end
                RUN_LO: begin
                    x_d = x_q - 1'b1;
                    s_d = s_q + 1'b1;
                    if (x_d == '0) st_d = DONE;
                end
                DONE: begin
                end
                default: st_d = DONE;
            endcase
        end
        dn_d = (st_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= RUN_HI;
            x_q  <= X0;
            y_q  <= Y0;
            s_q  <= '0;
            dn_q <= 1'b0;
        end else begin
            st_q <= st_d;
            x_q  <= x_d;
            y_q  <= y_d;
            s_q  <= s_d;
            dn_q <= dn_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign steps = s_q;
    assign phase = st_q;
    assign done  = dn_q;

    dual_counter_unwind_chk #(
        .W      (W),
        .X_MAX  (X_MAX),
        .X_KNEE (X_KNEE),
        .Y_INIT (Y_INIT)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .x     (x_q),
        .y     (y_q),
        .steps (s_q),
        .phase (st_q),
        .done  (dn_q)
    );

endmodule

// File: tb/tb_dual_counter_unwind.sv
// Directed and randomized bench for dual_counter_unwind (defaults).
// Expected vectors packed as {x, y, steps, phase, done}.
module tb_dual_counter_unwind;

    logic        clk = 1'b0;
    logic        rst;
    logic        selector;
    logic        restart;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] steps;
    logic [1:0]  phase;
    logic        done;

    int total = 0;
    int bad   = 0;

    dual_counter_unwind dut (
        .clk      (clk),
        .rst      (rst),
        .selector (selector),
        .restart  (restart),
        .x        (x),
        .y        (y),
        .steps    (steps),
        .phase    (phase),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] pack(int xv, int yv, int sv, int pv, int dv);
        return {11'(xv), 11'(yv), 11'(sv), 2'(pv), 1'(dv)};
    endfunction

    // Inputs change and outputs are read on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        restart = 1'b0;
        selector = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] e;
        rst = 1'b1;
        selector = 1'b1;
        restart = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        selector = 1'b0;
        restart = 1'b0;
        e = pack(200, 200, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({x, y, steps, phase, done} !== e) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                         i, x, y, steps, phase, done, e);
            end
        end
    endtask

    task automatic test_ramp_hi();
        logic [35:0] e;
        selector = 1'b1;
        repeat (99) tick();
        e = pack(101, 101, 99, 0, 0);
        total++;
        if ({x, y, steps, phase, done} !== e) begin
            bad++;
            $display("FAIL ramp_99: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                     x, y, steps, phase, done, e);
        end
        tick();
        e = pack(100, 100, 100, 1, 0);
        total++;
        if ({x, y, steps, phase, done} !== e) begin
            bad++;
            $display("FAIL knee_100: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                     x, y, steps, phase, done, e);
        end
        tick();
        e = pack(99, 100, 101, 1, 0);
        total++;
        if ({x, y, steps, phase, done} !== e) begin
            bad++;
            $display("FAIL past_knee: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                     x, y, steps, phase, done, e);
        end
    endtask

    task automatic test_ramp_lo();
        logic [35:0] e;
        repeat (98) tick();
        e = pack(1, 100, 199, 1, 0);
        total++;
        if ({x, y, steps, phase, done} !== e) begin
            bad++;
            $display("FAIL step_199: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                     x, y, steps, phase, done, e);
        end
        tick();
        e = pack(0, 100, 200, 2, 1);
        for (int i = 0; i <= 10; i++) begin
            total++;
            if ({x, y, steps, phase, done} !== e) begin
                bad++;
                $display("FAIL done_hold[%0d]: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                         i, x, y, steps, phase, done, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] e;
        restart = 1'b1;
        selector = 1'b1;
        tick();
        restart = 1'b0;
        e = pack(200, 200, 0, 0, 0);
        total++;
        if ({x, y, steps, phase, done} !== e) begin
            bad++;
            $display("FAIL restart_from_done: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                     x, y, steps, phase, done, e);
        end
        tick();
        e = pack(199, 199, 1, 0, 0);
        total++;
        if ({x, y, steps, phase, done} !== e) begin
            bad++;
            $display("FAIL first_step: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                     x, y, steps, phase, done, e);
        end
    endtask

    task automatic test_alternate();
        logic [35:0] e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            selector = (i % 2 == 0);
            tick();
        end
        selector = 1'b0;
        e = pack(190, 190, 10, 0, 0);
        total++;
        if ({x, y, steps, phase, done} !== e) begin
            bad++;
            $display("FAIL alternate: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                     x, y, steps, phase, done, e);
        end
    endtask

    task automatic test_restart();
        logic [35:0] e;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            selector = 1'b1;
            repeat (143) tick();
            e = pack(57, 100, 143, 1, 0);
            total++;
            if ({x, y, steps, phase, done} !== e) begin
                bad++;
                $display("FAIL run_to_57[%0d]: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                         k, x, y, steps, phase, done, e);
            end
            restart = 1'b1;
            rst = (k == 1);
            tick();
            restart = 1'b0;
            rst = 1'b0;
            selector = 1'b0;
            e = pack(200, 200, 0, 0, 0);
            total++;
            if ({x, y, steps, phase, done} !== e) begin
                bad++;
                $display("FAIL reload[%0d]: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                         k, x, y, steps, phase, done, e);
            end
        end
    endtask

    task automatic test_random();
        logic [35:0] e;
        int xm;
        do_reset();
        xm = 200;
        for (int i = 0; i < 250; i++) begin
            selector = ($urandom_range(0, 9) < 8);
            restart  = ($urandom_range(0, 59) == 0);
            tick();
            if (restart)                xm = 200;
            else if (selector && xm > 0) xm = xm - 1;
            e = pack(xm, (xm > 100) ? xm : 100, 200 - xm,
                     (xm > 100) ? 0 : ((xm == 0) ? 2 : 1), (xm == 0) ? 1 : 0);
            total++;
            if ({x, y, steps, phase, done} !== e) begin
                bad++;
                $display("FAIL random[%0d]: got x=%0d y=%0d steps=%0d phase=%0d done=%0d want %h",
                         i, x, y, steps, phase, done, e);
            end
        end
        selector = 1'b0;
        restart = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        selector = 1'b0;
        restart = 1'b0;
        @(negedge clk);
        test_reset();
        test_ramp_hi();
        test_ramp_lo();
        test_back_to_back();
        test_alternate();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
